dcache_port_arbiter: RTL and testbench
======================================

DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter CVA6Cfg; default config_pkg::cva6_cfg_empty; core configuration.
REQ-002 SHALL have parameter NrPorts; default 2; number of requesters, legal range 2..4.
REQ-003 SHALL have port clk_i; input; 1; single clock, all state on its rising edge.
REQ-004 SHALL have port rst_ni; input; 1; reset, asynchronous and active-low.
REQ-005 SHALL have port req_ports_i; input; dcache_req_t [NrPorts-1:0]; requester-side requests (index 0 = LSU, 1 = CVXIF).
REQ-006 SHALL have port rsp_ports_o; output; dcache_rsp_t [NrPorts-1:0]; responses routed back to each requester.
REQ-007 SHALL have port dcache_req_o; output; dcache_req_t; the single shared D$ port.
REQ-008 SHALL have port dcache_rsp_i; input; dcache_rsp_t; response from the shared D$ port.
REQ-009 SHALL have port busy_o; output; 1; high whenever state is not IDLE.
REQ-010 SHALL have port owner_o; output; $clog2(NrPorts); index of the current owner, 0 in IDLE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, WAIT_GNT, WAIT_RSP.
REQ-012 In IDLE, SHALL pick the first port with data_req=1, searching from rr_q upward with modulo-NrPorts wrap.
REQ-013 SHALL forward the picked port's request to dcache_req_o combinationally in the same cycle (zero-latency arbitration).
REQ-014 SHALL route dcache_rsp_i.data_gnt only to the owner; all other ports SHALL see data_gnt=0.
REQ-015 IDLE with pick and no gnt: SHALL latch the owner and go to WAIT_GNT, holding the owner until gnt.
REQ-016 On gnt with data_we=1 (store): SHALL return to IDLE and set rr_q = owner+1 mod NrPorts.
REQ-017 On gnt with data_we=0 (load): SHALL go to WAIT_RSP.
REQ-018 In WAIT_RSP, SHALL forward the owner's address_tag, tag_valid and kill_req; data_req to the cache SHALL be 0.
REQ-019 data_rvalid SHALL reach only the owner; data_rdata SHALL be broadcast to all ports.
REQ-020 WAIT_RSP exit on owner data_rvalid or owner kill_req: SHALL go to IDLE and set rr_q = owner+1 mod NrPorts.
REQ-021 If rvalid and kill_req occur in the same cycle, rvalid SHALL still be delivered to the owner; a single transition to IDLE.
REQ-022 A WAIT_GNT owner dropping data_req without gnt SHALL return the FSM to IDLE with rr_q unchanged.
REQ-023 In IDLE with no requester, dcache_req_o SHALL be all zero.
REQ-024 Non-owner requests SHALL be stalled (no gnt) and never reach the cache.
REQ-025 Grant-to-next-pick SHALL be zero bubble: a completion cycle in IDLE is immediately followed by a new arbitration.

Reset
REQ-026 On rst_ni low, asynchronously: state=IDLE, rr_q=0, owner=0.
REQ-027 During reset, every output SHALL be zero: dcache_req_o, all rsp_ports_o gnt/rvalid, busy_o and owner_o.
REQ-028 Reset mid-transaction SHALL discard ownership; no response SHALL be delivered for the aborted transaction after release.

Structure
REQ-029 dcache_req_t and dcache_rsp_t SHALL come from ariane_pkg; the FSM state enum SHALL be local to the module.
REQ-030 SHALL contain one sub-module, rr_picker: a combinational round-robin first-one finder with start pointer.

Verification
REQ-031 Single load: port0 load, gnt in cycle 1, rvalid in cycle 3 with rdata=0xDEADBEEF -> port0 gets gnt and rvalid; port1 sees none; rr_q=1.
REQ-032 Contention: both ports request in the same IDLE cycle with rr_q=0 -> port0 served first, then port1 in the next IDLE with no bubble cycle.
REQ-033 Gnt stall: port1 owner, gnt withheld 4 cycles while port0 requests -> owner stays 1 and port0 sees no gnt.
REQ-034 Kill: port0 load granted, kill_req asserted in WAIT_RSP -> FSM returns to IDLE next cycle; a later stray rvalid is not routed to any port.
REQ-035 Store: port1 store granted in cycle 0 -> IDLE at cycle 1, no WAIT_RSP visit, rr_q=0.
REQ-036 Reset: rst_ni asserted in WAIT_RSP -> all outputs 0 immediately; first post-reset pick starts from port0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Data-cache request/response port types shared by the LSU, CVXIF and the D$.
package ariane_pkg;

  localparam int unsigned DcacheIndexWidth = 12;
  localparam int unsigned DcacheTagWidth   = 44;
  localparam int unsigned DataWidth        = 64;

  typedef struct packed {
    logic [DcacheIndexWidth-1:0] address_index;
    logic [DcacheTagWidth-1:0]   address_tag;
    logic [DataWidth-1:0]        data_wdata;
    logic                        data_req;
    logic                        data_we;
    logic [DataWidth/8-1:0]      data_be;
    logic [1:0]                  data_size;
    logic                        kill_req;
    logic                        tag_valid;
  } dcache_req_t;

  typedef struct packed {
    logic                 data_gnt;
    logic                 data_rvalid;
    logic [DataWidth-1:0] data_rdata;
  } dcache_rsp_t;

endpackage

// File: rtl/config_pkg.sv
// Core configuration slice: only the fields the data-cache port arbiter looks at.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared limits and index arithmetic for the D$ port arbiter and its picker.
package dcache_port_arbiter_pkg;

  localparam int unsigned MinPorts = 2;
  localparam int unsigned MaxPorts = 4;

  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned modulus);
    return (base + offset) % modulus;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one finder: scans req starting at 'start', wrapping modulo N.
module rr_picker
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = W'(wrap_add(32'(start), k, N));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one D$ request port between several requesters; the owner keeps the port
// from pick until grant (stores) or until response/kill (loads).
module dcache_port_arbiter
  import ariane_pkg::*;
  import dcache_port_arbiter_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NrPorts = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  dcache_req_t [NrPorts-1:0]    req_ports_i,
  output dcache_rsp_t [NrPorts-1:0]    rsp_ports_o,
  output dcache_req_t                  dcache_req_o,
  input  dcache_rsp_t                  dcache_rsp_i,
  output logic                         busy_o,
  output logic [$clog2(NrPorts)-1:0]   owner_o
);

  localparam int unsigned IdxW = $clog2(NrPorts);

  if (NrPorts < MinPorts || NrPorts > MaxPorts) begin : g_bad_nr_ports
    $error("dcache_port_arbiter: NrPorts must be within 2..4");
  end
  if (CVA6Cfg.XLEN != 0 && CVA6Cfg.XLEN != DataWidth) begin : g_bad_xlen
    $error("dcache_port_arbiter: XLEN does not match the D$ data width");
  end

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic [NrPorts-1:0]  port_req;
  logic [NrPorts-1:0]  gnt_route;
  logic [NrPorts-1:0]  rvalid_route;
  dcache_req_t         req_mux;

  function automatic logic [IdxW-1:0] next_port(input logic [IdxW-1:0] cur);
    return IdxW'(wrap_add(32'(cur), 1, NrPorts));
  endfunction

  always_comb begin
    port_req = '0;
    for (int p = 0; p < NrPorts; p++) begin
      port_req[p] = req_ports_i[p].data_req;
    end
  end

  rr_picker #(
    .N (NrPorts),
    .W (IdxW)
  ) i_rr_picker (
    .req   (port_req),
    .start (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Arbitration in IDLE is zero-latency: the pick is forwarded and may be granted in the same cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    req_mux      = '0;
    gnt_route    = '0;
    rvalid_route = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          req_mux             = req_ports_i[pick_idx];
          gnt_route[pick_idx] = dcache_rsp_i.data_gnt;
          if (!dcache_rsp_i.data_gnt) begin
            owner_d = pick_idx;
            state_d = WAIT_GNT;
          end else if (req_ports_i[pick_idx].data_we) begin
            rr_d = next_port(pick_idx);
          end else begin
            owner_d = pick_idx;
            state_d = WAIT_RSP;
          end
        end
      end

      WAIT_GNT: begin
        req_mux = req_ports_i[owner_q];
        if (!req_ports_i[owner_q].data_req) begin
          state_d = IDLE;
        end else if (dcache_rsp_i.data_gnt) begin
          gnt_route[owner_q] = 1'b1;
          if (req_ports_i[owner_q].data_we) begin
            state_d = IDLE;
            rr_d    = next_port(owner_q);
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end

      WAIT_RSP: begin
        // Only the late tag phase of the load reaches the cache; no new request is issued.
        req_mux.address_tag   = req_ports_i[owner_q].address_tag;
        req_mux.tag_valid     = req_ports_i[owner_q].tag_valid;
        req_mux.kill_req      = req_ports_i[owner_q].kill_req;
        rvalid_route[owner_q] = dcache_rsp_i.data_rvalid;
        if (dcache_rsp_i.data_rvalid || req_ports_i[owner_q].kill_req) begin
          state_d = IDLE;
          rr_d    = next_port(owner_q);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to zero while reset is held, even though the request mux is combinational.
  always_comb begin
    rsp_ports_o  = '0;
    dcache_req_o = rst_ni ? req_mux : '0;
    busy_o       = rst_ni && (state_q != IDLE);
    owner_o      = (rst_ni && state_q != IDLE) ? owner_q : '0;
    for (int p = 0; p < NrPorts; p++) begin
      rsp_ports_o[p].data_gnt    = rst_ni & gnt_route[p];
      rsp_ports_o[p].data_rvalid = rst_ni & rvalid_route[p];
      rsp_ports_o[p].data_rdata  = rst_ni ? dcache_rsp_i.data_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with two requesters; rvalid deliveries are
// matched against a queue of expected (port, rdata) pairs.
module tb_dcache_port_arbiter;
  import ariane_pkg::*;

  logic              clk;
  logic              rst_n;
  dcache_req_t [1:0] req_ports;
  dcache_rsp_t [1:0] rsp_ports;
  dcache_req_t       dcache_req;
  dcache_rsp_t       dcache_rsp;
  logic              busy;
  logic [0:0]        owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          port;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t popped;

  localparam logic [43:0] TagA = 44'h0A0A;
  localparam logic [43:0] TagB = 44'h0B0B;
  localparam logic [43:0] TagC = 44'h0C0C;
  localparam logic [43:0] TagD = 44'h0D0D;
  localparam logic [43:0] TagE = 44'h0E0E;
  localparam logic [43:0] TagF = 44'h0F0F;
  localparam logic [43:0] TagG = 44'h1717;
  localparam logic [43:0] TagH = 44'h1818;

  dcache_port_arbiter #(
    .CVA6Cfg (config_pkg::cva6_cfg_empty),
    .NrPorts (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_ports_i  (req_ports),
    .rsp_ports_o  (rsp_ports),
    .dcache_req_o (dcache_req),
    .dcache_rsp_i (dcache_rsp),
    .busy_o       (busy),
    .owner_o      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int port, input logic req, input logic we,
                                input logic [43:0] tag, input logic kill);
    req_ports[port].data_req      = req;
    req_ports[port].data_we       = we;
    req_ports[port].address_tag   = tag;
    req_ports[port].address_index = tag[11:0];
    req_ports[port].data_wdata    = {20'h0, tag};
    req_ports[port].data_be       = 8'hFF;
    req_ports[port].data_size     = 2'b11;
    req_ports[port].kill_req      = kill;
    req_ports[port].tag_valid     = req | kill;
  endtask

  task automatic set_rsp(input logic gnt, input logic rvalid, input logic [63:0] rdata);
    dcache_rsp.data_gnt    = gnt;
    dcache_rsp.data_rvalid = rvalid;
    dcache_rsp.data_rdata  = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rsp_ports[p].data_rvalid === 1'b1) begin
        if (sb.size() == 0) begin
          check_output($sformatf("unexpected_rvalid_p%0d", p), 64'(rsp_ports[p].data_rvalid), 64'd0);
        end else begin
          popped = sb.pop_front();
          check_output("rvalid_port", 64'(p), 64'(popped.port));
          check_output("rvalid_data", rsp_ports[p].data_rdata, popped.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_ports = '0;
    dcache_rsp = '0;
    // Outputs stay zero while reset is held, even with an active requester and cache response.
    apply_stimulus(0, 1'b1, 1'b0, TagA, 1'b0);
    set_rsp(1'b1, 1'b1, 64'h55);
    #2;
    check_output("reset_req_zero", 64'(|dcache_req), 64'd0);
    check_output("reset_gnt0", 64'(rsp_ports[0].data_gnt), 64'd0);
    check_output("reset_rvalid0", 64'(rsp_ports[0].data_rvalid), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_owner", 64'(owner), 64'd0);
    next_cycle();
    next_cycle();
    rst_n      = 1'b1;
    req_ports  = '0;
    dcache_rsp = '0;

    $display("[TB] single load on port0");
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b0, TagA, 1'b0);
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("a_fwd_req", 64'(dcache_req.data_req), 64'd1);
    check_output("a_fwd_tag", 64'(dcache_req.address_tag), 64'(TagA));
    check_output("a_idle_busy", 64'(busy), 64'd0);
    next_cycle();
    set_rsp(1'b1, 1'b0, 64'h0);
    settle();
    check_output("a_waitgnt_busy", 64'(busy), 64'd1);
    check_output("a_owner", 64'(owner), 64'd0);
    check_output("a_gnt0", 64'(rsp_ports[0].data_gnt), 64'd1);
    check_output("a_gnt1", 64'(rsp_ports[1].data_gnt), 64'd0);
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, TagA, 1'b0);
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("a_waitrsp_noreq", 64'(dcache_req.data_req), 64'd0);
    check_output("a_waitrsp_tag", 64'(dcache_req.address_tag), 64'(TagA));
    next_cycle();
    set_rsp(1'b0, 1'b1, 64'hDEADBEEF);
    sb.push_back('{port: 0, data: 64'hDEADBEEF});
    settle();
    check_output("a_rdata_bcast1", rsp_ports[1].data_rdata, 64'hDEADBEEF);
    next_cycle();
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("a_back_idle", 64'(busy), 64'd0);

    $display("[TB] store on port1 granted at pick");
    next_cycle();
    apply_stimulus(1, 1'b1, 1'b1, TagB, 1'b0);
    set_rsp(1'b1, 1'b0, 64'h0);
    settle();
    check_output("s_gnt1", 64'(rsp_ports[1].data_gnt), 64'd1);
    check_output("s_gnt0", 64'(rsp_ports[0].data_gnt), 64'd0);
    check_output("s_fwd_tag", 64'(dcache_req.address_tag), 64'(TagB));
    next_cycle();
    apply_stimulus(1, 1'b0, 1'b0, TagB, 1'b0);
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("s_idle_after", 64'(busy), 64'd0);

    $display("[TB] contention with pointer at port0");
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b0, TagC, 1'b0);
    apply_stimulus(1, 1'b1, 1'b0, TagD, 1'b0);
    set_rsp(1'b1, 1'b0, 64'h0);
    settle();
    check_output("c_first_tag", 64'(dcache_req.address_tag), 64'(TagC));
    check_output("c_first_gnt0", 64'(rsp_ports[0].data_gnt), 64'd1);
    check_output("c_first_gnt1", 64'(rsp_ports[1].data_gnt), 64'd0);
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, TagC, 1'b0);
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("c_owner0", 64'(owner), 64'd0);
    check_output("c_stall_req", 64'(dcache_req.data_req), 64'd0);
    next_cycle();
    set_rsp(1'b0, 1'b1, 64'h1111);
    sb.push_back('{port: 0, data: 64'h1111});
    settle();
    check_output("c_nongnt1", 64'(rsp_ports[1].data_gnt), 64'd0);
    next_cycle();
    set_rsp(1'b1, 1'b0, 64'h0);
    settle();
    check_output("c_nobubble_busy", 64'(busy), 64'd0);
    check_output("c_second_tag", 64'(dcache_req.address_tag), 64'(TagD));
    check_output("c_second_gnt1", 64'(rsp_ports[1].data_gnt), 64'd1);
    check_output("c_second_gnt0", 64'(rsp_ports[0].data_gnt), 64'd0);
    next_cycle();
    apply_stimulus(1, 1'b0, 1'b0, TagD, 1'b0);
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("c_owner1", 64'(owner), 64'd1);
    next_cycle();
    set_rsp(1'b0, 1'b1, 64'h2222);
    sb.push_back('{port: 1, data: 64'h2222});
    next_cycle();
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("c_done_idle", 64'(busy), 64'd0);

    $display("[TB] port1 holds the port while grant is withheld");
    next_cycle();
    apply_stimulus(1, 1'b1, 1'b1, TagE, 1'b0);
    settle();
    check_output("g_pick_tag", 64'(dcache_req.address_tag), 64'(TagE));
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      apply_stimulus(0, 1'b1, 1'b0, TagF, 1'b0);
      settle();
      check_output($sformatf("g_owner_c%0d", i), 64'(owner), 64'd1);
      check_output($sformatf("g_gnt0_c%0d", i), 64'(rsp_ports[0].data_gnt), 64'd0);
      check_output($sformatf("g_tag_c%0d", i), 64'(dcache_req.address_tag), 64'(TagE));
    end
    next_cycle();
    set_rsp(1'b1, 1'b0, 64'h0);
    settle();
    check_output("g_gnt1", 64'(rsp_ports[1].data_gnt), 64'd1);
    check_output("g_gnt0", 64'(rsp_ports[0].data_gnt), 64'd0);
    next_cycle();
    apply_stimulus(1, 1'b0, 1'b0, TagE, 1'b0);
    settle();
    check_output("g_next_pick_busy", 64'(busy), 64'd0);
    check_output("g_next_pick_tag", 64'(dcache_req.address_tag), 64'(TagF));
    check_output("g_next_pick_gnt0", 64'(rsp_ports[0].data_gnt), 64'd1);

    $display("[TB] kill during response wait");
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, TagF, 1'b1);
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("k_fwd_kill", 64'(dcache_req.kill_req), 64'd1);
    check_output("k_busy", 64'(busy), 64'd1);
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, TagF, 1'b0);
    set_rsp(1'b0, 1'b1, 64'h3333);
    settle();
    check_output("k_idle", 64'(busy), 64'd0);
    check_output("k_stray_rv0", 64'(rsp_ports[0].data_rvalid), 64'd0);
    check_output("k_stray_rv1", 64'(rsp_ports[1].data_rvalid), 64'd0);
    next_cycle();
    set_rsp(1'b0, 1'b0, 64'h0);

    $display("[TB] owner withdraws while waiting for grant");
    next_cycle();
    apply_stimulus(1, 1'b1, 1'b0, TagG, 1'b0);
    settle();
    check_output("w_pick_tag", 64'(dcache_req.address_tag), 64'(TagG));
    next_cycle();
    apply_stimulus(1, 1'b0, 1'b0, TagG, 1'b0);
    settle();
    check_output("w_waitgnt_busy", 64'(busy), 64'd1);
    check_output("w_dropped_req", 64'(dcache_req.data_req), 64'd0);
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b0, TagH, 1'b0);
    apply_stimulus(1, 1'b1, 1'b0, TagG, 1'b0);
    settle();
    check_output("w_idle_again", 64'(busy), 64'd0);
    check_output("w_ptr_kept_tag", 64'(dcache_req.address_tag), 64'(TagG));
    next_cycle();
    set_rsp(1'b1, 1'b0, 64'h0);
    settle();
    check_output("w_gnt1", 64'(rsp_ports[1].data_gnt), 64'd1);
    next_cycle();
    apply_stimulus(1, 1'b0, 1'b0, TagG, 1'b0);
    set_rsp(1'b0, 1'b0, 64'h0);
    settle();
    check_output("w_waitrsp_owner", 64'(owner), 64'd1);

    $display("[TB] reset in the middle of a load");
    #2;
    rst_n = 1'b0;
    set_rsp(1'b1, 1'b1, 64'h4444);
    #1;
    check_output("r_req_zero", 64'(|dcache_req), 64'd0);
    check_output("r_busy", 64'(busy), 64'd0);
    check_output("r_owner", 64'(owner), 64'd0);
    check_output("r_gnt0", 64'(rsp_ports[0].data_gnt), 64'd0);
    check_output("r_rvalid1", 64'(rsp_ports[1].data_rvalid), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    apply_stimulus(1, 1'b1, 1'b0, TagG, 1'b0);
    set_rsp(1'b0, 1'b1, 64'h4444);
    settle();
    check_output("r_first_pick_tag", 64'(dcache_req.address_tag), 64'(TagH));
    check_output("r_post_rvalid1", 64'(rsp_ports[1].data_rvalid), 64'd0);
    check_output("r_post_busy", 64'(busy), 64'd0);
    next_cycle();
    req_ports  = '0;
    dcache_rsp = '0;
    next_cycle();
    next_cycle();
    check_output("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
